// File: rtl/fg_cfg_bus_writer_pkg.sv
// Shared types and helpers for the function generator config bus writer.
// Register k lives in the image byte counted from the MSB end.
package fg_cfg_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int BYTE_W   = 8;
  localparam int IMG_W    = NUM_REGS * BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  // CR0 is the MSB byte, so byte k starts at bit 8*(7-k)
  function automatic logic [BYTE_W-1:0] cfg_byte(
    input logic [IMG_W-1:0]  image,
    input logic [ADDR_W-1:0] k
  );
    logic [5:0] lsb;
    lsb = {~k, 3'b000};
    return image[lsb +: BYTE_W];
  endfunction

endpackage

// File: rtl/fg_cfg_bus_writer_if.sv
// Request handshake plus parallel config bus of the writer.
// master = requesting host, slave = the writer itself.
interface fg_cfg_bus_writer_if;
  import fg_cfg_pkg::*;

  logic [IMG_W-1:0]    cfg_i;
  logic [NUM_REGS-1:0] mask_i;
  logic                start_valid_i;
  logic                start_ready_o;
  logic                busy_o;
  logic                done_o;
  logic [BYTE_W-1:0]   bus_data_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic                bus_wr_o;

  modport master (
    output cfg_i,
    output mask_i,
    output start_valid_i,
    input  start_ready_o,
    input  busy_o,
    input  done_o,
    input  bus_data_o,
    input  bus_addr_o,
    input  bus_wr_o
  );

  modport slave (
    input  cfg_i,
    input  mask_i,
    input  start_valid_i,
    output start_ready_o,
    output busy_o,
    output done_o,
    output bus_data_o,
    output bus_addr_o,
    output bus_wr_o
  );

endinterface

// File: rtl/fg_cfg_bus_writer_next_reg_sel.sv
// Finds the lowest set bit of the remaining-register mask.
// Purely combinational; the writer registers the result.
module fg_next_reg_sel
  import fg_cfg_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec,
  output logic                found,
  output logic [ADDR_W-1:0]   idx
);

  // scan downward so the lowest set index wins
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

endmodule

// File: rtl/fg_cfg_bus_writer.sv
// Sequences timed writes of a captured config image onto the
// generator's parallel config bus, one register per set mask bit.
module fg_cfg_bus_writer
  import fg_cfg_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fg_cfg_bus_writer_if.slave   bus
);

  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ?
                         SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_L = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CNT_W = $clog2(MAX_L + 1);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IMG_W-1:0]    img;
  logic [NUM_REGS-1:0] rem;
  logic [NUM_REGS-1:0] scan_vec;
  logic                found;
  logic [ADDR_W-1:0]   idx;
  logic [BYTE_W-1:0]   data;
  logic [ADDR_W-1:0]   addr;
  logic                wr;
  logic                done;
  logic                ready;
  logic                busy;
  logic                accept;
  logic                cnt_zero;

  assign accept   = bus.start_valid_i && ready;
  assign cnt_zero = (cnt == '0);

  // idle: scan the incoming mask; otherwise scan with the served bit cleared
  always_comb begin
    scan_vec = bus.mask_i;
    if (state != IDLE) begin
      scan_vec = rem & ~(NUM_REGS'(1) << addr);
    end
  end

  fg_next_reg_sel u_sel (
    .vec   (scan_vec),
    .found (found),
    .idx   (idx)
  );

  // phase sequencer; every bus and status output is a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      img   <= '0;
      rem   <= '0;
      data  <= '0;
      addr  <= '0;
      wr    <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            img   <= bus.cfg_i;
            rem   <= bus.mask_i;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (found) begin
              state <= SETUP;
              cnt   <= SETUP_LD;
              addr  <= idx;
              data  <= cfg_byte(bus.cfg_i, idx);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            state <= STROBE;
            cnt   <= STROBE_LD;
            wr    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_zero) begin
            state <= HOLD;
            cnt   <= HOLD_LD;
            wr    <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            rem <= scan_vec;
            if (found) begin
              state <= SETUP;
              cnt   <= SETUP_LD;
              addr  <= idx;
              data  <= cfg_byte(img, idx);
            end else begin
              state <= DONE;
              done  <= 1'b1;
              addr  <= '0;
              data  <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          wr    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready_o = ready;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;
  assign bus.bus_data_o    = data;
  assign bus.bus_addr_o    = addr;
  assign bus.bus_wr_o      = wr;

endmodule

// File: tb/tb_fg_cfg_bus_writer.sv
// Directed + random bench for fg_cfg_bus_writer: cycle-exact timing
// model on a default instance, receiver loopback on a fast instance.
module tb_fg_cfg_bus_writer;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 4;
  localparam int P = S + T + H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fg_cfg_bus_writer_if a_if ();
  fg_cfg_bus_writer_if b_if ();

  fg_cfg_bus_writer #(
    .SETUP_CYCLES  (S),
    .STROBE_CYCLES (T),
    .HOLD_CYCLES   (H)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  fg_cfg_bus_writer #(
    .SETUP_CYCLES  (1),
    .STROBE_CYCLES (3),
    .HOLD_CYCLES   (3)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  // rising-edge counter on instance A's write enable
  logic a_prev = 1'b0;
  int   a_pulses = 0;
  always @(posedge clk) begin
    if (a_if.bus_wr_o && !a_prev) a_pulses <= a_pulses + 1;
    a_prev <= a_if.bus_wr_o;
  end

  // receiver: 2-FF enable sync, data/addr sampled directly
  logic [1:0] rx_sync;
  logic [7:0] rx [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      rx_sync <= 2'b00;
      for (int i = 0; i < 8; i++) rx[i] <= 8'h00;
    end else begin
      rx_sync <= {rx_sync[0], b_if.bus_wr_o};
      if (rx_sync[1]) rx[b_if.bus_addr_o] <= b_if.bus_data_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_ready"}, 64'(a_if.start_ready_o), 64'd1);
    chk({tag, "_busy"},  64'(a_if.busy_o), 64'd0);
    chk({tag, "_done"},  64'(a_if.done_o), 64'd0);
    chk({tag, "_wr"},    64'(a_if.bus_wr_o), 64'd0);
    chk({tag, "_addr"},  64'(a_if.bus_addr_o), 64'd0);
    chk({tag, "_data"},  64'(a_if.bus_data_o), 64'd0);
  endtask

  // one transfer on A, every cycle compared against the timing rules
  task automatic run_a(input logic [63:0] cfg, input logic [7:0] mask,
                       input bit noisy);
    int sel[$];
    int n;
    int p0;
    int j;
    int ph;
    bit in_x;
    logic [63:0] e_wr, e_addr, e_data;
    for (int k = 0; k < 8; k++) if (mask[k]) sel.push_back(k);
    n  = sel.size();
    p0 = a_pulses;
    @(negedge clk);
    chk("a_ready_pre", 64'(a_if.start_ready_o), 64'd1);
    a_if.cfg_i = cfg;
    a_if.mask_i = mask;
    a_if.start_valid_i = 1'b1;
    @(posedge clk);
    #1;
    a_if.start_valid_i = 1'b0;
    for (int c = 1; c <= n * P + 2; c++) begin
      @(negedge clk);
      in_x = (c <= n * P);
      e_wr = 0;
      e_addr = 0;
      e_data = 0;
      if (in_x) begin
        j  = (c - 1) / P;
        ph = (c - 1) % P;
        e_wr   = 64'(ph >= S && ph < S + T);
        e_addr = 64'(sel[j]);
        e_data = (cfg >> (56 - 8 * sel[j])) & 64'hFF;
      end
      chk($sformatf("a_wr c%0d", c), 64'(a_if.bus_wr_o), e_wr);
      chk($sformatf("a_addr c%0d", c), 64'(a_if.bus_addr_o), e_addr);
      chk($sformatf("a_data c%0d", c), 64'(a_if.bus_data_o), e_data);
      chk($sformatf("a_done c%0d", c), 64'(a_if.done_o),
          64'(c == n * P + 1));
      chk($sformatf("a_busy c%0d", c), 64'(a_if.busy_o),
          64'(c <= n * P + 1));
      chk($sformatf("a_ready c%0d", c), 64'(a_if.start_ready_o),
          64'(c == n * P + 2));
      if (noisy && c <= n * P + 1) begin
        a_if.cfg_i = {$urandom, $urandom};
        a_if.mask_i = 8'($urandom);
        a_if.start_valid_i = 1'b1;
      end else begin
        a_if.start_valid_i = 1'b0;
      end
    end
    chk("a_pulse_count", 64'(a_pulses - p0), 64'(n));
  endtask

  logic [7:0]  exp_rx [8];
  logic [63:0] rc;
  logic [7:0]  rm;
  bit          seen;

  initial begin
    a_if.cfg_i = '0;
    a_if.mask_i = '0;
    a_if.start_valid_i = 1'b0;
    b_if.cfg_i = '0;
    b_if.mask_i = '0;
    b_if.start_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) exp_rx[i] = 8'h00;

    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk_idle_a("rst");
    chk("rst_b_ready", 64'(b_if.start_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // all registers, ascending bytes
    run_a(64'h0102030405060708, 8'hFF, 1'b0);
    // first and last only
    run_a(64'hA5000000000000C3, 8'h81, 1'b0);
    // empty mask
    run_a(64'hDEADBEEFCAFEF00D, 8'h00, 1'b0);
    // input noise while busy, then a clean follow-up
    run_a({$urandom, $urandom}, 8'($urandom) | 8'h10, 1'b1);
    run_a({$urandom, $urandom}, 8'($urandom), 1'b0);
    repeat (4) run_a({$urandom, $urandom}, 8'($urandom), 1'b0);

    // reset in the middle of a strobe
    @(negedge clk);
    a_if.cfg_i = 64'h1122334455667788;
    a_if.mask_i = 8'hFF;
    a_if.start_valid_i = 1'b1;
    @(posedge clk);
    #1;
    a_if.start_valid_i = 1'b0;
    repeat (S + 1) @(negedge clk);
    chk("mid_wr_high", 64'(a_if.bus_wr_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle_a("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(a_if.done_o), 64'd0);
      chk("midrst_no_busy", 64'(a_if.busy_o), 64'd0);
    end

    // loopback through the receiver model on the fast instance
    for (int it = 0; it < 12; it++) begin
      rc = {$urandom, $urandom};
      rm = 8'($urandom);
      @(negedge clk);
      b_if.cfg_i = rc;
      b_if.mask_i = rm;
      b_if.start_valid_i = 1'b1;
      @(posedge clk);
      #1;
      b_if.start_valid_i = 1'b0;
      b_if.cfg_i = ~rc;
      seen = 1'b0;
      for (int w = 0; w < 200 && !seen; w++) begin
        @(negedge clk);
        seen = b_if.done_o;
      end
      chk($sformatf("b_done_seen it%0d", it), 64'(seen), 64'd1);
      for (int k = 0; k < 8; k++) begin
        if (rm[k]) exp_rx[k] = rc[63 - 8 * k -: 8];
      end
      repeat (2) @(negedge clk);
      chk($sformatf("b_ready it%0d", it), 64'(b_if.start_ready_o), 64'd1);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rx%0d it%0d", k, it), 64'(rx[k]), 64'(exp_rx[k]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
